sbus_ahbl_master: RTL and testbench
===================================

Name: sbus_ahbl_master

Overview:
- Bridges a single-outstanding SBUS-style valid/ready request port onto an AHB-Lite manager port.
- Used where an SBUS initiator (debug system-bus access, DMA-lite sequencer) must reach an AHB-Lite fabric: splitter, SRAM, IPC registers.
- This is the opposite direction to the AHB-to-SBUS pipestage used on the APU subordinate side.
- Handles wait states, the two-phase AHB ERROR response, byte-lane steering, and local rejection of misaligned or illegal requests.

Parameters:
W_ADDR, 32, width of sbus_addr and ahblm_haddr
HPROT_VAL, 4'b0011, constant driven on ahblm_hprot (data, privileged)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sbus_addr  in  W_ADDR  request address; stable while sbus_vld is high
sbus_write  in  1  1 = write, 0 = read
sbus_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
sbus_vld  in  1  request valid; held until the sbus_rdy cycle, dropped on the edge after it
sbus_wdata  in  32  write data, right-justified; must be valid from the second cycle of sbus_vld
sbus_rdy  out  1  single-cycle completion strobe
sbus_err  out  1  error qualifier, valid only with sbus_rdy
sbus_rdata  out  32  read data, right-justified and zero-extended; valid with sbus_rdy
busy  out  1  high in any state other than IDLE
ahblm_haddr  out  W_ADDR  AHB address
ahblm_hwrite  out  1  AHB write
ahblm_htrans  out  2  AHB transfer type: 2'b00 or 2'b10 only
ahblm_hsize  out  3  {1'b0, sbus_size}
ahblm_hburst  out  3  constant 3'b000
ahblm_hprot  out  4  constant HPROT_VAL
ahblm_hmastlock  out  1  constant 0
ahblm_hready  in  1  AHB ready
ahblm_hresp  in  1  AHB error response
ahblm_hwdata  out  32  AHB write data, lane-replicated
ahblm_hrdata  in  32  AHB read data

Behaviour:
- Reset state:
  - FSM in IDLE.
  - htrans = 0, haddr = 0, hwrite = 0, hsize = 0, hwdata = 0.
  - sbus_rdy = 0, sbus_err = 0, sbus_rdata = 0, busy = 0.
  - All outputs are registered.
- FSM states are IDLE, ADDR, DATA, ERR2, RESP.
- IDLE, on sbus_vld = 1:
  - If the request is illegal, go to RESP with err = 1 and issue no bus transfer. Illegal means size = 3, size = 1 with addr[0] = 1, or size = 2 with addr[1:0] != 0.
  - Otherwise register haddr, hwrite and hsize, set htrans = NONSEQ, and go to ADDR.
- ADDR:
  - Address phase is held while ahblm_hready = 0.
  - When hready = 1: htrans → IDLE, register hwdata from sbus_wdata, go to DATA.
  - Lane replication: byte → {4{wdata[7:0]}}, halfword → {2{wdata[15:0]}}, word → unchanged.
- DATA:
  - hready = 0 and hresp = 0: wait.
  - hready = 0 and hresp = 1: go to ERR2.
  - hready = 1 and hresp = 0: capture read data, go to RESP with err = 0.
  - Read-data capture: byte → hrdata[8*addr[1:0] +: 8], zero-extended; halfword → hrdata[16*addr[1] +: 16], zero-extended; word → as is. Writes return rdata = 0.
  - hready = 1 and hresp = 1 (protocol violation): treat as error and go to RESP with err = 1.
- ERR2: wait for hready = 1 (hresp is expected high), then go to RESP with err = 1.
- RESP: sbus_rdy = 1 for exactly one cycle; next state is IDLE.
  - Requests are never accepted from RESP.
  - sbus_vld still high in the first IDLE cycle after RESP is an initiator error and is not required behaviour.
- Latency:
  - Zero-wait read or write: sbus_vld sampled at edge 0 → NONSEQ in cycle 1 → data phase in cycle 2 → sbus_rdy in cycle 3.
  - Each wait state adds 1 cycle.
  - An illegal request gives sbus_rdy in cycle 1.
- Transfer rules:
  - Only one transfer is outstanding; no pipelined address phases.
  - htrans is never BUSY or SEQ.
- sbus_vld dropped mid-transaction: the transfer still completes on AHB and the sbus_rdy strobe is still produced; no abort.
- Asserting rst_n mid-transfer returns the block to IDLE immediately (htrans = 0). The bus-side consequences are the system's responsibility.

Test Plan:
- Word read 0x0000_8004, zero wait, hrdata = 0xDEADBEEF → NONSEQ cycle 1, hsize = 2, sbus_rdy cycle 3, rdata = 0xDEADBEEF, err = 0.
- Byte write addr 0x0003, wdata = 0x000000A5, 2 wait states in data phase → hwdata = 0xA5A5A5A5, hsize = 0, sbus_rdy cycle 5, err = 0.
- Halfword read addr 0x0002, hrdata = 0x1234ABCD → rdata = 0x00001234; byte read addr 0x0001 → rdata = 0x000000AB.
- Two-phase ERROR on write (cycle hready = 0/hresp = 1, then hready = 1/hresp = 1) → sbus_rdy with err = 1 exactly one cycle after the second phase; htrans stays 0 throughout.
- Misaligned word at addr 0x0002, and size = 3 → no NONSEQ ever driven, sbus_rdy and err = 1 in cycle 1.
- Address phase held with hready = 0 for 3 cycles, then rst_n pulsed during a data phase → haddr/htrans stable while stalled; after reset all outputs are 0 and busy = 0; the next request completes normally.

Source files
------------

// File: rtl/sbus_ahbl_master_if.sv
`default_nettype none
// ============================================================================
// Module   : sbus_ahbl_master_if
// Purpose  : SBUS request/response port and AHB-Lite manager port bundled
//            together. The "master" modport is the bridge side; the "slave"
//            modport is the SBUS initiator plus AHB fabric seen from outside.
// Revision : 1.0  initial release
// ============================================================================
interface sbus_ahbl_master_if #(
  parameter int W_ADDR = 32
);
  // SBUS request side
  logic [W_ADDR-1:0] sbus_addr;
  logic              sbus_write;
  logic [1:0]        sbus_size;
  logic              sbus_vld;
  logic [31:0]       sbus_wdata;
  logic              sbus_rdy;
  logic              sbus_err;
  logic [31:0]       sbus_rdata;

  // AHB-Lite manager side
  logic [W_ADDR-1:0] ahblm_haddr;
  logic              ahblm_hwrite;
  logic [1:0]        ahblm_htrans;
  logic [2:0]        ahblm_hsize;
  logic [2:0]        ahblm_hburst;
  logic [3:0]        ahblm_hprot;
  logic              ahblm_hmastlock;
  logic              ahblm_hready;
  logic              ahblm_hresp;
  logic [31:0]       ahblm_hwdata;
  logic [31:0]       ahblm_hrdata;

  modport master (
    input  sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
    output sbus_rdy, sbus_err, sbus_rdata,
    output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
    output ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
    input  ahblm_hready, ahblm_hresp, ahblm_hrdata
  );

  modport slave (
    output sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
    input  sbus_rdy, sbus_err, sbus_rdata,
    input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
    input  ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
    output ahblm_hready, ahblm_hresp, ahblm_hrdata
  );
endinterface
`default_nettype wire

// File: rtl/sbus_ahbl_master.sv
`default_nettype none
// ============================================================================
// Module   : sbus_ahbl_master
// Purpose  : Single-outstanding SBUS valid/ready request to AHB-Lite manager
//            bridge. Handles wait states, the two-phase ERROR response,
//            write-lane replication, read-lane extraction and local
//            rejection of misaligned/illegal requests.
// Revision : 1.0  initial release
// ============================================================================
module sbus_ahbl_master #(
  parameter int         W_ADDR    = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  sbus_ahbl_master_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR2 = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              w_resp_err;
  logic              w_illegal;
  logic [31:0]       w_wdata_lanes;
  logic [31:0]       w_rdata_lane;

  logic [W_ADDR-1:0] r_haddr;
  logic              r_hwrite;
  logic [1:0]        r_size;
  logic [1:0]        r_htrans;
  logic [31:0]       r_hwdata;
  logic              r_rdy;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              r_busy;

  // Request legality: size 3 never legal, halfword/word must be naturally aligned
  always_comb begin
    w_illegal = 1'b0;
    case (bus.sbus_size)
      2'd1:    w_illegal = bus.sbus_addr[0];
      2'd2:    w_illegal = |bus.sbus_addr[1:0];
      2'd3:    w_illegal = 1'b1;
      default: w_illegal = 1'b0;
    endcase
  end

  // Replicate right-justified write data across every lane the slave may sample
  always_comb begin
    w_wdata_lanes = bus.sbus_wdata;
    case (r_size)
      2'd0:    w_wdata_lanes = {4{bus.sbus_wdata[7:0]}};
      2'd1:    w_wdata_lanes = {2{bus.sbus_wdata[15:0]}};
      default: w_wdata_lanes = bus.sbus_wdata;
    endcase
  end

  // Pick the addressed lane out of HRDATA and zero-extend; writes return zero
  always_comb begin
    w_rdata_lane = bus.ahblm_hrdata;
    case (r_size)
      2'd0:    w_rdata_lane = {24'd0, bus.ahblm_hrdata[{r_haddr[1:0], 3'b000} +: 8]};
      2'd1:    w_rdata_lane = {16'd0, bus.ahblm_hrdata[{r_haddr[1], 4'b0000} +: 16]};
      default: w_rdata_lane = bus.ahblm_hrdata;
    endcase
    if (r_hwrite) begin
      w_rdata_lane = 32'd0;
    end
  end

  // Next-state and the error qualifier carried into RESP
  always_comb begin
    w_state_nxt = r_state;
    w_resp_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sbus_vld) begin
          w_state_nxt = w_illegal ? S_RESP : S_ADDR;
          w_resp_err  = w_illegal;
        end
      end
      S_ADDR: begin
        if (bus.ahblm_hready) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // hready with hresp is a protocol violation; still reported as error
        if (bus.ahblm_hready) begin
          w_state_nxt = S_RESP;
          w_resp_err  = bus.ahblm_hresp;
        end else if (bus.ahblm_hresp) begin
          w_state_nxt = S_ERR2;
        end
      end
      S_ERR2: begin
        if (bus.ahblm_hready) begin
          w_state_nxt = S_RESP;
          w_resp_err  = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, AHB address/data phase registers and SBUS response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_size   <= 2'd0;
      r_htrans <= HTRANS_IDLE;
      r_hwdata <= 32'd0;
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      // RESP always exits to IDLE, so entering RESP yields a one-cycle strobe
      r_rdy   <= (w_state_nxt == S_RESP);
      r_err   <= (w_state_nxt == S_RESP) && w_resp_err;

      if ((r_state == S_IDLE) && bus.sbus_vld && !w_illegal) begin
        r_haddr  <= bus.sbus_addr;
        r_hwrite <= bus.sbus_write;
        r_size   <= bus.sbus_size;
        r_htrans <= HTRANS_NONSEQ;
      end

      // Write data is sampled at the end of the address phase, i.e. no
      // earlier than the second cycle of sbus_vld
      if ((r_state == S_ADDR) && bus.ahblm_hready) begin
        r_htrans <= HTRANS_IDLE;
        r_hwdata <= w_wdata_lanes;
      end

      if ((w_state_nxt == S_RESP) && (r_state != S_RESP)) begin
        r_rdata <= w_resp_err ? 32'd0 : w_rdata_lane;
      end
    end
  end

  assign bus.ahblm_haddr     = r_haddr;
  assign bus.ahblm_hwrite    = r_hwrite;
  assign bus.ahblm_htrans    = r_htrans;
  assign bus.ahblm_hsize     = {1'b0, r_size};
  assign bus.ahblm_hburst    = 3'b000;
  assign bus.ahblm_hprot     = HPROT_VAL;
  assign bus.ahblm_hmastlock = 1'b0;
  assign bus.ahblm_hwdata    = r_hwdata;
  assign bus.sbus_rdy        = r_rdy;
  assign bus.sbus_err        = r_err;
  assign bus.sbus_rdata      = r_rdata;
  assign busy                = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sbus_ahbl_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbus_ahbl_master
// Purpose  : Directed plus randomized bench for sbus_ahbl_master. The bench
//            plays both the SBUS initiator and a scripted AHB-Lite slave and
//            predicts every cycle from a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sbus_ahbl_master;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  sbus_ahbl_master_if #(.W_ADDR(32)) bus ();

  sbus_ahbl_master #(.W_ADDR(32), .HPROT_VAL(4'b0011)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd0) || (s == 2'd1 && (a % 2) == 0) || (s == 2'd2 && (a % 4) == 0);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] d, input logic [1:0] s);
    if (s == 2'd0) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (s == 2'd1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] hr, input logic [31:0] a,
                                            input logic [1:0] s);
    if (s == 2'd0) return (hr >> (8 * (a % 4))) & 32'h0000_00FF;
    if (s == 2'd1) return (hr >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
    return hr;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_htrans"}, bus.ahblm_htrans, 32'd0);
    chk({tag, "_haddr"},  bus.ahblm_haddr,  32'd0);
    chk({tag, "_hwrite"}, bus.ahblm_hwrite, 32'd0);
    chk({tag, "_hsize"},  bus.ahblm_hsize,  32'd0);
    chk({tag, "_hwdata"}, bus.ahblm_hwdata, 32'd0);
    chk({tag, "_rdy"},    bus.sbus_rdy,     32'd0);
    chk({tag, "_err"},    bus.sbus_err,     32'd0);
    chk({tag, "_rdata"},  bus.sbus_rdata,   32'd0);
    chk({tag, "_busy"},   busy,             32'd0);
  endtask

  // One SBUS request. aw/dw: wait cycles in address/data phase.
  // emode 0 = OKAY, 1 = two-phase ERROR, 2 = hready+hresp together.
  // rst_at != 0 pulses rst_n in that cycle and abandons the request.
  task automatic run_txn(input logic [31:0] addr, input bit wr, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int aw, input int dw, input int emode, input int rst_at);
    bit          legal;
    bit          exp_err;
    int          lat;
    int          dstart;
    int          k;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_trans;

    legal  = is_legal(addr, sz);
    dstart = aw + 2;
    if (!legal) begin
      lat = 1; exp_err = 1'b1;
    end else if (emode == 1) begin
      lat = aw + dw + 4; exp_err = 1'b1;
    end else begin
      lat = aw + dw + 3; exp_err = (emode == 2);
    end
    exp_rdata = (exp_err || wr) ? 32'd0 : rd_model(rd, addr, sz);

    bus.sbus_addr    = addr;
    bus.sbus_write   = wr;
    bus.sbus_size    = sz;
    bus.sbus_vld     = 1'b1;
    bus.sbus_wdata   = ~wd;
    bus.ahblm_hrdata = rd;
    bus.ahblm_hready = 1'b1;
    bus.ahblm_hresp  = 1'b0;

    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1) bus.sbus_wdata = wd;
      if (c == lat + 1) bus.sbus_vld = 1'b0;

      bus.ahblm_hready = 1'b1;
      bus.ahblm_hresp  = 1'b0;
      if (legal) begin
        if (c <= aw) begin
          bus.ahblm_hready = 1'b0;
        end else if (c >= dstart) begin
          k = c - dstart;
          if (k < dw) begin
            bus.ahblm_hready = 1'b0;
          end else if (k == dw && emode == 1) begin
            bus.ahblm_hready = 1'b0;
            bus.ahblm_hresp  = 1'b1;
          end else if (k == dw && emode == 2) begin
            bus.ahblm_hresp  = 1'b1;
          end else if (k == dw + 1 && emode == 1) begin
            bus.ahblm_hresp  = 1'b1;
          end
        end
      end

      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        rst_n            = 1'b1;
        bus.sbus_vld     = 1'b0;
        bus.ahblm_hready = 1'b1;
        bus.ahblm_hresp  = 1'b0;
        return;
      end

      chk("rdy",  bus.sbus_rdy, 32'(c == lat));
      chk("busy", busy,         32'(c <= lat));
      exp_trans = (legal && c <= aw + 1) ? 2'b10 : 2'b00;
      chk("htrans", bus.ahblm_htrans, exp_trans);
      if (exp_trans == 2'b10) begin
        chk("haddr",  bus.ahblm_haddr,  addr);
        chk("hsize",  bus.ahblm_hsize,  {1'b0, sz});
        chk("hwrite", bus.ahblm_hwrite, wr);
      end
      if (legal && wr && c == dstart) chk("hwdata", bus.ahblm_hwdata, lanes(wd, sz));
      if (c == lat) begin
        chk("err",   bus.sbus_err,   exp_err);
        chk("rdata", bus.sbus_rdata, exp_rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  // Directed steps followed by randomized requests
  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    int          r;
    int          em;

    bus.sbus_addr    = '0;
    bus.sbus_write   = 1'b0;
    bus.sbus_size    = 2'd0;
    bus.sbus_vld     = 1'b0;
    bus.sbus_wdata   = '0;
    bus.ahblm_hready = 1'b1;
    bus.ahblm_hresp  = 1'b0;
    bus.ahblm_hrdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("hburst",    bus.ahblm_hburst,    32'd0);
    chk("hprot",     bus.ahblm_hprot,     32'h3);
    chk("hmastlock", bus.ahblm_hmastlock, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(32'h0000_8004, 1'b0, 2'd2, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0);
    run_txn(32'h0000_0003, 1'b1, 2'd0, 32'h0000_00A5, 32'h0,         0, 2, 0, 0);
    run_txn(32'h0000_0002, 1'b0, 2'd1, 32'h0,         32'h1234_ABCD, 0, 0, 0, 0);
    run_txn(32'h0000_0001, 1'b0, 2'd0, 32'h0,         32'h1234_ABCD, 0, 0, 0, 0);
    run_txn(32'h0000_0040, 1'b1, 2'd2, 32'hCAFE_F00D, 32'h0,         0, 0, 1, 0);
    run_txn(32'h0000_0044, 1'b0, 2'd2, 32'h0,         32'h5555_AAAA, 1, 1, 2, 0);
    run_txn(32'h0000_0002, 1'b0, 2'd2, 32'h0,         32'h1111_2222, 0, 0, 0, 0);
    run_txn(32'h0000_0010, 1'b1, 2'd3, 32'h7777_7777, 32'h0,         0, 0, 0, 0);
    run_txn(32'h0000_0100, 1'b1, 2'd1, 32'h0000_BEEF, 32'h0,         3, 4, 0, 6);
    @(posedge clk); #1;
    check_all_zero("postrst");
    run_txn(32'h0000_8004, 1'b0, 2'd2, 32'h0,         32'h89AB_CDEF, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      r  = $urandom_range(0, 9);
      em = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      run_txn(a, 1'($urandom_range(0, 1)), s, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), em, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
